// File: rtl/sim_step_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// sim_step_scheduler_pkg
// Shared types for the loop-mode step scheduler.
//   timer_state_t : step timer states (IDLE/COUNT/FIRE/HOLD)
//   speed_t       : speed level codes as shown on speedlvl (01/10/11)
//   btn_state_t   : speed pushbutton press/release tracking
//   next_speed()  : speed rotation 01 -> 10 -> 11 -> 01
// ---------------------------------------------------------------------------
package sim_step_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_FIRE  = 2'b10,
        ST_HOLD  = 2'b11
    } timer_state_t;

    typedef enum logic [1:0] {
        SPEED1 = 2'b01,
        SPEED2 = 2'b10,
        SPEED3 = 2'b11
    } speed_t;

    typedef enum logic {
        BTN_UP   = 1'b0,
        BTN_DOWN = 1'b1
    } btn_state_t;

    // Code 00 is never produced; it recovers to the slowest speed.
    function automatic speed_t next_speed(input speed_t s);
        case (s)
            SPEED1:  return SPEED2;
            SPEED2:  return SPEED3;
            default: return SPEED1;
        endcase
    endfunction

endpackage

// File: rtl/sim_step_scheduler_speed_select.sv
// ---------------------------------------------------------------------------
// sim_step_scheduler_speed_select
// Speed-level selection from the debounced speed pushbutton. The level
// advances on the release edge, so a held button advances it exactly once.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous, active-high
//   speed_btn in  debounced pushbutton level
//   speedlvl  out current speed code (01, 10, 11)
// ---------------------------------------------------------------------------
module sim_step_scheduler_speed_select
    import sim_step_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       speed_btn,
    output logic [1:0] speedlvl
);

    btn_state_t btn_state, btn_state_next;
    speed_t     speed, speed_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_state <= BTN_UP;
            speed     <= SPEED1;
        end else begin
            btn_state <= btn_state_next;
            speed     <= speed_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        btn_state_next = btn_state;
        speed_next     = speed;
        case (btn_state)
            BTN_UP: begin
                if (speed_btn) btn_state_next = BTN_DOWN;
            end
            BTN_DOWN: begin
                if (!speed_btn) begin
                    btn_state_next = BTN_UP;
                    speed_next     = next_speed(speed);
                end
            end
            default: btn_state_next = BTN_UP;
        endcase
    end

    assign speedlvl = speed;

endmodule

// File: rtl/sim_step_scheduler.sv
// ---------------------------------------------------------------------------
// sim_step_scheduler
// Paces loop-mode simulation: counts cycles at the selected speed, issues a
// one-cycle step pulse (yes), waits for the engine to finish the step, then
// restarts the count.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous, active-high
//   strtcnt   in  run enable from the loop controller
//   clr       in  synchronous clear of timer and generation count
//   sim_done  in  engine finished the step (only looked at while holding)
//   speed_btn in  debounced speed pushbutton
//   yes       out one-cycle step pulse, decoded from the FIRE state
//   speedlvl  out current speed code (01, 10, 11)
//   delay     out current delay-counter value
//   gen_count out steps issued since last clr/reset (saturating)
//   busy      out a step is outstanding (FIRE or HOLD)
// ---------------------------------------------------------------------------
module sim_step_scheduler
    import sim_step_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PERIOD1 = 50_000_000,
    parameter int unsigned PERIOD2 = 25_000_000,
    parameter int unsigned PERIOD3 = 5_000_000,
    parameter int unsigned GEN_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strtcnt,
    input  logic             clr,
    input  logic             sim_done,
    input  logic             speed_btn,
    output logic             yes,
    output logic [1:0]       speedlvl,
    output logic [CNT_W-1:0] delay,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy
);

    // Terminal delay value per speed: the step fires once delay reaches P-1.
    localparam logic [CNT_W-1:0] LIMIT1 = CNT_W'(PERIOD1 - 1);
    localparam logic [CNT_W-1:0] LIMIT2 = CNT_W'(PERIOD2 - 1);
    localparam logic [CNT_W-1:0] LIMIT3 = CNT_W'(PERIOD3 - 1);

    timer_state_t     state, state_next;
    logic [CNT_W-1:0] delay_next;
    logic [GEN_W-1:0] gen_next;
    logic [CNT_W-1:0] limit;

    sim_step_scheduler_speed_select u_speed_select (
        .clk       (clk),
        .reset     (reset),
        .speed_btn (speed_btn),
        .speedlvl  (speedlvl)
    );

    always_comb begin
        case (speedlvl)
            SPEED2:  limit = LIMIT2;
            SPEED3:  limit = LIMIT3;
            default: limit = LIMIT1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            delay     <= '0;
            gen_count <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            delay     <= delay_next;
            gen_count <= gen_next;
            busy      <= (state_next == ST_FIRE) || (state_next == ST_HOLD);
        end
    end

    always_comb begin
        state_next = state;
        delay_next = delay;
        gen_next   = gen_count;

        case (state)
            ST_IDLE: begin
                delay_next = '0;
                if (strtcnt) state_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (!strtcnt) begin
                    state_next = ST_IDLE;
                    delay_next = '0;
                end else if (delay >= limit) begin
                    // >= rather than == so a period lowered mid-count still
                    // fires next cycle; delay stays at its last value.
                    state_next = ST_FIRE;
                end else begin
                    delay_next = delay + CNT_W'(1);
                end
            end
            ST_FIRE: begin
                state_next = ST_HOLD;
                if (gen_count != '1) gen_next = gen_count + GEN_W'(1);
            end
            ST_HOLD: begin
                // Dropping the run enable wins over a finished step.
                if (!strtcnt) begin
                    state_next = ST_IDLE;
                    delay_next = '0;
                end else if (sim_done) begin
                    state_next = ST_COUNT;
                    delay_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                delay_next = '0;
            end
        endcase

        if (clr) begin
            state_next = ST_IDLE;
            delay_next = '0;
            gen_next   = '0;
        end
    end

    assign yes = (state == ST_FIRE);

endmodule

// File: tb/tb_sim_step_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sim_step_scheduler
// Directed scenarios plus a randomized run, all compared against a
// behavioural model of the step scheduler kept in this bench.
// ---------------------------------------------------------------------------
module tb_sim_step_scheduler;

    localparam int CW = 32;
    localparam int GW = 4;
    localparam int P1 = 4;
    localparam int P2 = 8;
    localparam int P3 = 2;
    localparam int GEN_MAX = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          reset, strtcnt, clr, sim_done, speed_btn;
    logic          yes, busy;
    logic [1:0]    speedlvl;
    logic [CW-1:0] delay;
    logic [GW-1:0] gen_count;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: what the scheduler is doing, in plain terms.
    bit m_counting, m_firing, m_waiting, m_btn_down;
    int m_count, m_gens, m_speed;

    sim_step_scheduler #(
        .CNT_W   (CW),
        .PERIOD1 (P1),
        .PERIOD2 (P2),
        .PERIOD3 (P3),
        .GEN_W   (GW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .strtcnt   (strtcnt),
        .clr       (clr),
        .sim_done  (sim_done),
        .speed_btn (speed_btn),
        .yes       (yes),
        .speedlvl  (speedlvl),
        .delay     (delay),
        .gen_count (gen_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic model_update();
        int period;
        if (reset) begin
            m_counting = 0; m_firing = 0; m_waiting = 0; m_btn_down = 0;
            m_count = 0; m_gens = 0; m_speed = 1;
            return;
        end
        period = (m_speed == 1) ? P1 : (m_speed == 2) ? P2 : P3;
        if (clr) begin
            m_counting = 0; m_firing = 0; m_waiting = 0;
            m_count = 0; m_gens = 0;
        end else if (m_firing) begin
            m_firing  = 0;
            m_waiting = 1;
            if (m_gens < GEN_MAX) m_gens++;
        end else if (m_waiting) begin
            if (!strtcnt) begin
                m_waiting = 0; m_count = 0;
            end else if (sim_done) begin
                m_waiting = 0; m_counting = 1; m_count = 0;
            end
        end else if (m_counting) begin
            if (!strtcnt) begin
                m_counting = 0; m_count = 0;
            end else if (m_count >= period - 1) begin
                m_counting = 0; m_firing = 1;
            end else begin
                m_count++;
            end
        end else begin
            m_count = 0;
            if (strtcnt) m_counting = 1;
        end
        if (m_btn_down && !speed_btn) m_speed = (m_speed % 3) + 1;
        m_btn_down = speed_btn;
    endtask

    function automatic logic [39:0] exp_vec();
        return {m_firing, m_firing || m_waiting, 2'(m_speed), 32'(m_count), 4'(m_gens)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strtcnt = 1'($urandom); clr = 1'($urandom);
            sim_done = 1'($urandom); speed_btn = 1'($urandom);
            tick();
        end
        vectors++; if (yes !== 1'b0) begin miscompares++; $display("FAIL reset_yes: got %b expected 0", yes); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (speedlvl !== 2'b01) begin miscompares++; $display("FAIL reset_speedlvl: got %b expected 01", speedlvl); end
        vectors++; if (delay !== '0) begin miscompares++; $display("FAIL reset_delay: got %0d expected 0", delay); end
        vectors++; if (gen_count !== '0) begin miscompares++; $display("FAIL reset_gen: got %0d expected 0", gen_count); end
        reset = 1'b0; strtcnt = 1'b0; clr = 1'b0; sim_done = 1'b0; speed_btn = 1'b0;
        tick();
        vectors++; if ({yes, busy, speedlvl, delay, gen_count} !== exp_vec()) begin
            miscompares++; $display("FAIL reset_model: got %h expected %h", {yes, busy, speedlvl, delay, gen_count}, exp_vec());
        end
    endtask

    task automatic test_step_period();
        int n;
        clr = 1'b1; tick(); clr = 1'b0;
        strtcnt = 1'b1; sim_done = 1'b1;
        tick();
        n = 0;
        while (yes !== 1'b1 && n < 50) begin tick(); n++; end
        vectors++; if (n != P1) begin miscompares++; $display("FAIL first_step_latency: got %0d expected %0d", n, P1); end
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin tick(); n++; end while (yes !== 1'b1 && n < 50);
            vectors++; if (n != P1 + 2) begin miscompares++; $display("FAIL step_spacing%0d: got %0d expected %0d", k, n, P1 + 2); end
        end
        vectors++; if ({yes, busy, speedlvl, delay, gen_count} !== exp_vec()) begin
            miscompares++; $display("FAIL step_model: got %h expected %h", {yes, busy, speedlvl, delay, gen_count}, exp_vec());
        end
    endtask

    task automatic test_hold();
        int n;
        clr = 1'b1; tick(); clr = 1'b0;
        strtcnt = 1'b1; sim_done = 1'b0;
        n = 0;
        while (yes !== 1'b1 && n < 50) begin tick(); n++; end
        vectors++; if (yes !== 1'b1) begin miscompares++; $display("FAIL hold_first_yes: got %b expected 1", yes); end
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL hold_busy%0d: got %b expected 1", i, busy); end
            vectors++; if (yes !== 1'b0) begin miscompares++; $display("FAIL hold_yes%0d: got %b expected 0", i, yes); end
            vectors++; if (delay !== CW'(P1 - 1)) begin miscompares++; $display("FAIL hold_delay%0d: got %0d expected %0d", i, delay, P1 - 1); end
        end
        sim_done = 1'b1; tick(); sim_done = 1'b0;
        vectors++; if ({busy, delay} !== {1'b0, CW'(0)}) begin
            miscompares++; $display("FAIL hold_release: got busy=%b delay=%0d expected busy=0 delay=0", busy, delay);
        end
        vectors++; if ({yes, busy, speedlvl, delay, gen_count} !== exp_vec()) begin
            miscompares++; $display("FAIL hold_model: got %h expected %h", {yes, busy, speedlvl, delay, gen_count}, exp_vec());
        end
    endtask

    task automatic test_speed();
        logic [1:0] exp_seq [3] = '{2'b10, 2'b11, 2'b01};
        strtcnt = 1'b0; sim_done = 1'b0; tick();
        for (int k = 0; k < 3; k++) begin
            speed_btn = 1'b1; tick();
            speed_btn = 1'b0; tick();
            vectors++; if (speedlvl !== exp_seq[k]) begin miscompares++; $display("FAIL speed_step%0d: got %b expected %b", k, speedlvl, exp_seq[k]); end
        end
        speed_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++; if (speedlvl !== 2'b01) begin miscompares++; $display("FAIL speed_held%0d: got %b expected 01", i, speedlvl); end
        end
        speed_btn = 1'b0; tick();
        vectors++; if (speedlvl !== 2'b10) begin miscompares++; $display("FAIL speed_release: got %b expected 10", speedlvl); end
    endtask

    task automatic test_speed_switch();
        int n;
        clr = 1'b1; tick(); clr = 1'b0;
        strtcnt = 1'b1; sim_done = 1'b0;
        n = 0;
        while (delay !== CW'(3) && n < 50) begin tick(); n++; end
        speed_btn = 1'b1; tick();
        speed_btn = 1'b0; tick();
        vectors++; if ({speedlvl, delay, yes} !== {2'b11, CW'(5), 1'b0}) begin
            miscompares++; $display("FAIL switch_pre: got spd=%b delay=%0d yes=%b expected spd=11 delay=5 yes=0", speedlvl, delay, yes);
        end
        tick();
        vectors++; if (yes !== 1'b1) begin miscompares++; $display("FAIL switch_fire: got %b expected 1", yes); end
        vectors++; if (delay !== CW'(5)) begin miscompares++; $display("FAIL switch_delay: got %0d expected 5", delay); end
        tick();
        vectors++; if ({yes, busy, speedlvl, delay, gen_count} !== exp_vec()) begin
            miscompares++; $display("FAIL switch_model: got %h expected %h", {yes, busy, speedlvl, delay, gen_count}, exp_vec());
        end
    endtask

    task automatic test_clr();
        int n;
        clr = 1'b1; tick(); clr = 1'b0;
        strtcnt = 1'b1; sim_done = 1'b1;
        n = 0;
        while (!(gen_count === GW'(7) && busy === 1'b1 && yes === 1'b0) && n < 200) begin tick(); n++; end
        vectors++; if (gen_count !== GW'(7)) begin miscompares++; $display("FAIL clr_setup_gen: got %0d expected 7", gen_count); end
        clr = 1'b1; tick(); clr = 1'b0;
        vectors++; if ({yes, busy, delay, gen_count} !== {1'b0, 1'b0, CW'(0), GW'(0)}) begin
            miscompares++; $display("FAIL clr_state: got yes=%b busy=%b delay=%0d gen=%0d expected all 0", yes, busy, delay, gen_count);
        end
        vectors++; if (speedlvl !== 2'b11) begin miscompares++; $display("FAIL clr_speed: got %b expected 11", speedlvl); end
    endtask

    task automatic test_drop();
        int n;
        clr = 1'b1; tick(); clr = 1'b0;
        strtcnt = 1'b1; sim_done = 1'b0;
        n = 0;
        while (delay !== CW'(2) && n < 50) begin tick(); n++; end
        strtcnt = 1'b0; tick();
        vectors++; if ({busy, delay} !== {1'b0, CW'(0)}) begin
            miscompares++; $display("FAIL drop_count: got busy=%b delay=%0d expected busy=0 delay=0", busy, delay);
        end
        strtcnt = 1'b1;
        n = 0;
        while (yes !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL drop_hold_busy: got %b expected 1", busy); end
        strtcnt = 1'b0; sim_done = 1'b1; tick();
        sim_done = 1'b0; strtcnt = 1'b1; tick();
        vectors++; if (delay !== CW'(0)) begin miscompares++; $display("FAIL drop_hold_idle: got delay=%0d expected 0", delay); end
        tick();
        vectors++; if (delay !== CW'(1)) begin miscompares++; $display("FAIL drop_restart: got delay=%0d expected 1", delay); end
    endtask

    task automatic test_saturate();
        clr = 1'b1; tick(); clr = 1'b0;
        strtcnt = 1'b1; sim_done = 1'b1;
        for (int i = 0; i < 120; i++) tick();
        vectors++; if (gen_count !== GW'(GEN_MAX)) begin miscompares++; $display("FAIL gen_saturate: got %0d expected %0d", gen_count, GEN_MAX); end
        vectors++; if ({yes, busy, speedlvl, delay, gen_count} !== exp_vec()) begin
            miscompares++; $display("FAIL saturate_model: got %h expected %h", {yes, busy, speedlvl, delay, gen_count}, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 499) == 0);
            clr      = ($urandom_range(0, 99) == 0);
            strtcnt  = ($urandom_range(0, 19) != 0);
            sim_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) speed_btn = ~speed_btn;
            tick();
            vectors++; if ({yes, busy, speedlvl, delay, gen_count} !== exp_vec()) begin
                miscompares++; $display("FAIL random_cycle%0d: got %h expected %h", i, {yes, busy, speedlvl, delay, gen_count}, exp_vec());
            end
        end
        reset = 1'b0; clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; strtcnt = 1'b0; clr = 1'b0; sim_done = 1'b0; speed_btn = 1'b0;
        test_reset();
        test_step_period();
        test_hold();
        test_speed();
        test_speed_switch();
        test_clr();
        test_drop();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
